codecracker_led_seq: RTL and testbench
======================================

# codecracker_led_seq

LED pattern sequencer for the CodeCracker LED bank. The block is an Avalon-MM write-only master that owns the LED PIO `s1` slave, which has 10 data bits and a data register at word address 0. It turns a small configuration handshake from game logic into timed PIO writes for static, blink and scroll patterns. It also arbitrates a higher-priority one-shot "event flash" requester that pre-empts the animation for a fixed hold time and then restores it.

## Interface
Parameters:
- `LED_W`, 10: LED/PIO data width; `writedata[31:LED_W]` is always 0.
- `TICK_DIV`, 5000000: clock cycles per animation tick (10 Hz at 50 MHz); minimum 2.
- `HOLD_TICKS`, 20: number of ticks an event pattern is held; minimum 1.

Ports:
- `clk`, in, 1: single clock; everything is in this domain.
- `reset_n`, in, 1: asynchronous active-low reset.
- `cfg_valid`, in, 1: one-cycle request to load `cfg_mode`/`cfg_pattern`; always accepted.
- `cfg_mode`, in, 2: 0 OFF, 1 STATIC, 2 BLINK, 3 SCROLL.
- `cfg_pattern`, in, LED_W: base pattern.
- `evt_req`, in, 1: level request for an event flash.
- `evt_pattern`, in, LED_W: pattern shown during the event; sampled at accept.
- `evt_ack`, out, 1: one-cycle pulse when an event is accepted.
- `busy`, out, 1: high whenever state is not IDLE.
- `avm_address`, out, 2: constant 0.
- `avm_chipselect`, out, 1: write strobe, together with `avm_write_n`.
- `avm_write_n`, out, 1: active-low write.
- `avm_writedata`, out, 32: `{0, frame}`.

## Operation
- States: IDLE (settled), RUN (animating, waiting for a tick), WR (single bus-write cycle), EVT (holding the event pattern).
- Bus write: exactly one cycle with `avm_chipselect`=1 and `avm_write_n`=0. There is no waitrequest, because the PIO captures the data in that cycle. `avm_chipselect`=0 and `avm_write_n`=1 at all other times.
- Config accept: latch mode and pattern, restart the tick divider, then go to WR with the first frame:
  - OFF: frame 0.
  - STATIC, BLINK, SCROLL: frame `cfg_pattern`.
- After a WR:
  - OFF or STATIC: go to IDLE.
  - BLINK or SCROLL: go to RUN.
  - Event write: go to EVT.
- RUN on tick:
  - BLINK toggles the frame between the pattern and 0.
  - SCROLL rotates the frame left by 1 within LED_W (bit LED_W-1 moves to bit 0).
  - Go to WR.
- Event accept (`evt_req` high and state not EVT):
  - Pulse `evt_ack`.
  - Restart the divider.
  - Write `evt_pattern`, then enter EVT.
  - The animation frame freezes.
- EVT:
  - `evt_req` is ignored, with no ack.
  - A `cfg_valid` is latched but not written.
  - On the HOLD_TICKS-th tick, write the current frame (the newly latched config's first frame if a cfg arrived), restart the divider, and resume RUN or IDLE.
- Simultaneous `cfg_valid` and `evt_req` in the same cycle: the cfg is latched and the event wins the bus. The restore write is the new config's first frame.
- `cfg_valid` arriving during WR or RUN: the new config wins. The frame restarts at the new pattern and no stale write follows.
- An event accepted while IDLE (STATIC or OFF) restores the static frame and returns to IDLE.
- Reset mid-operation aborts any write immediately. No write is issued on reset exit, because the PIO also resets to 0.

## Timing
- Reset values:
  - `avm_write_n`=1.
  - `avm_chipselect`=0, `avm_address`=0, `avm_writedata`=0.
  - `evt_ack`=0, `busy`=0.
  - Mode OFF, frame 0, divider 0.
- Config sampled at edge N: write in cycle N+1. First tick at N+TICK_DIV, its write at N+TICK_DIV+1, and one write every TICK_DIV cycles after that.
- Event sampled at edge M: `evt_ack` and the event write in cycle M+1. Restore write at M+HOLD_TICKS·TICK_DIV+1. The next animation write follows TICK_DIV cycles later.
- Divider: counts 0..TICK_DIV-1 and emits a one-cycle tick at TICK_DIV-1. It holds at 0 in IDLE.

## Configuration
- `CODECRACKER_LED_SEQ_EVENT_EN` defined: event arbitration, the EVT state and the hold counter are compiled in.
- Not defined:
  - `evt_req` and `evt_pattern` are ignored.
  - `evt_ack` is tied to 0.
  - The EVT state and hold counter are removed.
  - All other behaviour is unchanged.

## Structure
- Package `codecracker_led_pkg`:
  - Mode enum (OFF/STATIC/BLINK/SCROLL).
  - State enum.
  - `PIO_DATA_ADDR`=2'd0.
  - `LED_W_DEF`=10.
- Sub-module `codecracker_led_tick_div`: parameterised divider with `restart` and `enable` inputs and a `tick` output.

## Test plan
All scenarios use TICK_DIV=4 and HOLD_TICKS=2.
- Reset held, then released → `avm_write_n`=1, `avm_chipselect`=0, `busy`=0, `evt_ack`=0, and no write for 50 cycles.
- cfg STATIC 0x2A5 at edge 10 → one write of 0x2A5 in cycle 11, `busy` low from cycle 12, and no further writes for 100 cycles.
- cfg BLINK 0x3FF at edge N → writes 0x3FF at N+1, 0x000 at N+5 and 0x3FF at N+9.
- cfg SCROLL 0x201 → successive writes 0x201, 0x003, 0x006, 0x00C, spaced 4 cycles apart.
- During SCROLL with frame 0x006, `evt_req` with 0x155 at edge M → `evt_ack` and write 0x155 at M+1, write 0x006 at M+9, write 0x00C at M+13. A second `evt_req` inside the hold produces no ack.
- `cfg_valid` (STATIC 0x0F0) and `evt_req` (0x3C3) at the same edge M → write 0x3C3 at M+1, write 0x0F0 at M+9, then IDLE. With the macro undefined → write 0x0F0 at M+1 and `evt_ack` never asserts.

Source files
------------

// File: rtl/codecracker_led_pkg.sv
// Shared types and constants for the CodeCracker LED sequencer.
package codecracker_led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_STATIC = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_SCROLL = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WR   = 2'd2,
        ST_EVT  = 2'd3
    } state_e;

    localparam logic [1:0]  PIO_DATA_ADDR = 2'd0;
    localparam int unsigned LED_W_DEF     = 10;

    function automatic logic mode_animates(input mode_e m);
        return (m == MODE_BLINK) || (m == MODE_SCROLL);
    endfunction

endpackage

// File: rtl/codecracker_led_tick_div.sv
// Animation tick divider: counts 0..TICK_DIV-1, one-cycle tick on the last count,
// held at 0 while disabled or restarted.
module codecracker_led_tick_div #(
    parameter int unsigned TICK_DIV = 5000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    input  logic enable,
    output logic tick
);

    localparam int unsigned    CNT_W    = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart || !enable) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/codecracker_led_seq.sv
// LED pattern sequencer driving the LED PIO over Avalon-MM (write-only).
// Event-flash arbitration is compiled in with CODECRACKER_LED_SEQ_EVENT_EN.
module codecracker_led_seq
    import codecracker_led_pkg::*;
#(
    parameter int unsigned LED_W      = LED_W_DEF,
    parameter int unsigned TICK_DIV   = 5000000,
    parameter int unsigned HOLD_TICKS = 20
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cfg_valid,
    input  logic [1:0]       cfg_mode,
    input  logic [LED_W-1:0] cfg_pattern,
    input  logic             evt_req,
    input  logic [LED_W-1:0] evt_pattern,
    output logic             evt_ack,
    output logic             busy,
    output logic [1:0]       avm_address,
    output logic             avm_chipselect,
    output logic             avm_write_n,
    output logic [31:0]      avm_writedata
);

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [LED_W-1:0] pattern_q, pattern_d;
    logic [LED_W-1:0] frame_q, frame_d;
    logic [LED_W-1:0] wr_data_q, wr_data_d;
    logic [LED_W-1:0] frame_step;
    logic             evt_ack_q, evt_ack_d;
    logic             restart;
    logic             div_en;
    logic             tick;

`ifdef CODECRACKER_LED_SEQ_EVENT_EN
    localparam int unsigned       HOLD_W    = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

    logic              evt_wr_q, evt_wr_d;
    logic              in_evt;
    logic [HOLD_W-1:0] hold_q, hold_d;

    // The event's own write cycle belongs to the event, so a held evt_req is not re-accepted there.
    assign in_evt = (state_q == ST_EVT) || ((state_q == ST_WR) && evt_wr_q);
`else
    logic unused_evt;
    assign unused_evt = ^{evt_req, evt_pattern} ^ (HOLD_TICKS == 0);
`endif

    // Divider runs whenever the sequencer is not settled, so it sits at 0 in IDLE.
    assign div_en = (state_d != ST_IDLE);

    codecracker_led_tick_div #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_div (
        .clk    (clk),
        .reset_n(reset_n),
        .restart(restart),
        .enable (div_en),
        .tick   (tick)
    );

    always_comb begin
        if (mode_q == MODE_SCROLL) begin
            frame_step = {frame_q[LED_W-2:0], frame_q[LED_W-1]};
        end else if (frame_q == pattern_q) begin
            frame_step = '0;
        end else begin
            frame_step = pattern_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        pattern_d = pattern_q;
        frame_d   = frame_q;
        wr_data_d = wr_data_q;
        restart   = 1'b0;
        evt_ack_d = 1'b0;
`ifdef CODECRACKER_LED_SEQ_EVENT_EN
        evt_wr_d  = evt_wr_q;
        hold_d    = hold_q;
`endif
        if (cfg_valid) begin
            mode_d    = mode_e'(cfg_mode);
            pattern_d = cfg_pattern;
            frame_d   = (mode_e'(cfg_mode) == MODE_OFF) ? '0 : cfg_pattern;
        end
`ifdef CODECRACKER_LED_SEQ_EVENT_EN
        if (in_evt) begin
            if (state_q == ST_WR) begin
                state_d  = ST_EVT;
                evt_wr_d = 1'b0;
            end else if (tick) begin
                if (hold_q == HOLD_LAST) begin
                    state_d   = ST_WR;
                    wr_data_d = frame_d;
                    restart   = 1'b1;
                    hold_d    = '0;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
        end else if (evt_req) begin
            state_d   = ST_WR;
            evt_wr_d  = 1'b1;
            wr_data_d = evt_pattern;
            restart   = 1'b1;
            evt_ack_d = 1'b1;
            hold_d    = '0;
        end else
`endif
        if (cfg_valid) begin
            state_d   = ST_WR;
            wr_data_d = frame_d;
            restart   = 1'b1;
        end else begin
            case (state_q)
                ST_WR:   state_d = mode_animates(mode_q) ? ST_RUN : ST_IDLE;
                ST_RUN: begin
                    if (tick) begin
                        frame_d   = frame_step;
                        wr_data_d = frame_step;
                        state_d   = ST_WR;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_OFF;
            pattern_q <= '0;
            frame_q   <= '0;
            wr_data_q <= '0;
            evt_ack_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            pattern_q <= pattern_d;
            frame_q   <= frame_d;
            wr_data_q <= wr_data_d;
            evt_ack_q <= evt_ack_d;
        end
    end

`ifdef CODECRACKER_LED_SEQ_EVENT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            evt_wr_q <= 1'b0;
            hold_q   <= '0;
        end else begin
            evt_wr_q <= evt_wr_d;
            hold_q   <= hold_d;
        end
    end
`endif

    always_comb begin
        avm_address    = PIO_DATA_ADDR;
        avm_chipselect = (state_q == ST_WR);
        avm_write_n    = (state_q != ST_WR);
        avm_writedata  = 32'(wr_data_q);
        busy           = (state_q != ST_IDLE);
`ifdef CODECRACKER_LED_SEQ_EVENT_EN
        evt_ack        = evt_ack_q;
`else
        evt_ack        = 1'b0;
`endif
    end

endmodule

// File: tb/tb_codecracker_led_seq.sv
// Self-checking bench for codecracker_led_seq (TICK_DIV=4, HOLD_TICKS=2);
// expectations adapt to CODECRACKER_LED_SEQ_EVENT_EN.
module tb_codecracker_led_seq;
    import codecracker_led_pkg::*;

    localparam int unsigned TD = 4;
    localparam int unsigned HT = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [1:0]  cfg_mode = 2'd0;
    logic [9:0]  cfg_pattern = '0;
    logic        evt_req = 1'b0;
    logic [9:0]  evt_pattern = '0;
    logic        evt_ack, busy, avm_chipselect, avm_write_n;
    logic [1:0]  avm_address;
    logic [31:0] avm_writedata;

    typedef struct {
        int unsigned t;
        logic [9:0]  d;
    } wr_t;

    wr_t         wr_q[$];
    wr_t         got[$];
    wr_t         exp_q[$];
    int unsigned ack_q[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          passes = 0;
    int          proto_err = 0;

    codecracker_led_seq #(
        .LED_W     (10),
        .TICK_DIV  (TD),
        .HOLD_TICKS(HT)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cfg_valid     (cfg_valid),
        .cfg_mode      (cfg_mode),
        .cfg_pattern   (cfg_pattern),
        .evt_req       (evt_req),
        .evt_pattern   (evt_pattern),
        .evt_ack       (evt_ack),
        .busy          (busy),
        .avm_address   (avm_address),
        .avm_chipselect(avm_chipselect),
        .avm_write_n   (avm_write_n),
        .avm_writedata (avm_writedata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Writes and acks are stamped with the cycle number they occupy (edge count + 1).
    always @(negedge clk) begin
        if (avm_chipselect === 1'b1 && avm_write_n === 1'b0) begin
            wr_q.push_back('{cyc + 1, avm_writedata[9:0]});
            if (avm_writedata[31:10] !== '0 || avm_address !== 2'd0) proto_err++;
        end else if (avm_chipselect !== 1'b0 || avm_write_n !== 1'b1) begin
            proto_err++;
        end
        if (evt_ack === 1'b1) ack_q.push_back(cyc + 1);
        else if (evt_ack !== 1'b0) proto_err++;
    end

    // Frame shown k ticks after a config was loaded.
    function automatic logic [9:0] exp_frame(input int mode, input int pat, input int k);
        int r;
        int v;
        case (mode)
            0:       v = 0;
            1:       v = pat;
            2:       v = (k % 2 == 0) ? pat : 0;
            default: begin
                r = k % 10;
                v = ((pat << r) | (pat >> (10 - r))) & 1023;
            end
        endcase
        return 10'(v);
    endfunction

    task automatic wait_until(input int unsigned t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue_cfg(input logic [1:0] mode, input logic [9:0] pat, output int unsigned n);
        cfg_mode    = mode;
        cfg_pattern = pat;
        cfg_valid   = 1'b1;
        n           = cyc + 1;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
    endtask

    task automatic collect(input int unsigned lo, input int unsigned hi);
        got.delete();
        foreach (wr_q[i]) if (wr_q[i].t > lo && wr_q[i].t <= hi) got.push_back(wr_q[i]);
    endtask

    task automatic test_reset;
        int bad;
        bad = 0;
        #2;
        checks++;
        if ({avm_write_n, avm_chipselect, busy, evt_ack} !== 4'b1000 || avm_writedata !== 32'd0
            || avm_address !== 2'd0)
            $display("FAIL reset_values: got wn=%b cs=%b busy=%b ack=%b data=0x%0h, expected 1 0 0 0 0x0",
                     avm_write_n, avm_chipselect, busy, evt_ack, avm_writedata);
        else passes++;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        wr_q.delete();
        repeat (50) begin
            @(posedge clk);
            #1;
            if (busy !== 1'b0 || avm_chipselect !== 1'b0 || evt_ack !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) $display("FAIL reset_idle: got %0d active cycles, expected 0", bad);
        else passes++;
        checks++;
        if (wr_q.size() !== 0) $display("FAIL reset_nowrite: got %0d writes, expected 0", wr_q.size());
        else passes++;
    endtask

    task automatic test_static;
        logic [1:0]  mode;
        logic [9:0]  pat;
        int unsigned n;
        for (int it = 0; it < 4; it++) begin
            mode = (it == 0) ? MODE_STATIC : 2'($urandom_range(0, 1));
            pat  = (it == 0) ? 10'h2A5 : 10'($urandom_range(0, 1023));
            issue_cfg(mode, pat, n);
            checks++;
            if (busy !== 1'b1) $display("FAIL static_busy_wr: got %b, expected 1", busy);
            else passes++;
            wait_until(n + 1);
            checks++;
            if (busy !== 1'b0) $display("FAIL static_busy_idle: got %b, expected 0", busy);
            else passes++;
            wait_until(n + 100);
            collect(n, n + 100);
            exp_q.delete();
            exp_q.push_back('{n + 1, exp_frame(int'(mode), int'(pat), 0)});
            checks++;
            if (got.size() !== exp_q.size())
                $display("FAIL static_count: got %0d writes, expected %0d", got.size(), exp_q.size());
            else passes++;
            for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
                checks++;
                if (got[i].t !== exp_q[i].t || got[i].d !== exp_q[i].d)
                    $display("FAIL static_write%0d: got t=%0d d=0x%03h, expected t=%0d d=0x%03h",
                             i, got[i].t, got[i].d, exp_q[i].t, exp_q[i].d);
                else passes++;
            end
        end
    endtask

    task automatic test_animate(input logic [1:0] mode, input logic [9:0] first_pat, input int nwr);
        logic [9:0]  pat;
        int unsigned n;
        for (int it = 0; it < 2; it++) begin
            pat = (it == 0) ? first_pat : 10'($urandom_range(1, 1023));
            issue_cfg(mode, pat, n);
            wait_until(n + TD * nwr);
            collect(n, n + TD * nwr);
            exp_q.delete();
            for (int k = 0; k < nwr; k++) exp_q.push_back('{n + 1 + TD * k, exp_frame(int'(mode), int'(pat), k)});
            checks++;
            if (got.size() !== exp_q.size())
                $display("FAIL anim%0d_count: got %0d writes, expected %0d", mode, got.size(), exp_q.size());
            else passes++;
            for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
                checks++;
                if (got[i].t !== exp_q[i].t || got[i].d !== exp_q[i].d)
                    $display("FAIL anim%0d_write%0d: got t=%0d d=0x%03h, expected t=%0d d=0x%03h",
                             mode, i, got[i].t, got[i].d, exp_q[i].t, exp_q[i].d);
                else passes++;
            end
        end
    endtask

    task automatic test_cfg_override;
        logic [9:0]  spat, pat;
        logic [1:0]  mode;
        int unsigned n0, n;
        for (int it = 0; it < 3; it++) begin
            spat = 10'($urandom_range(1, 1023));
            issue_cfg(MODE_SCROLL, spat, n0);
            wait_until(n0 + $urandom_range(1, 10));
            mode = 2'($urandom_range(0, 1));
            pat  = 10'($urandom_range(0, 1023));
            issue_cfg(mode, pat, n);
            wait_until(n + 40);
            collect(n0, n + 40);
            exp_q.delete();
            for (int k = 0; n0 + 1 + TD * k <= n; k++) exp_q.push_back('{n0 + 1 + TD * k, exp_frame(3, int'(spat), k)});
            exp_q.push_back('{n + 1, exp_frame(int'(mode), int'(pat), 0)});
            checks++;
            if (got.size() !== exp_q.size())
                $display("FAIL override_count: got %0d writes, expected %0d", got.size(), exp_q.size());
            else passes++;
            for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
                checks++;
                if (got[i].t !== exp_q[i].t || got[i].d !== exp_q[i].d)
                    $display("FAIL override_write%0d: got t=%0d d=0x%03h, expected t=%0d d=0x%03h",
                             i, got[i].t, got[i].d, exp_q[i].t, exp_q[i].d);
                else passes++;
            end
        end
    endtask

    task automatic test_event;
        logic [9:0]  ep;
        int unsigned n0, m, hi, nack;
        for (int it = 0; it < 2; it++) begin
            ack_q.delete();
            ep = (it == 0) ? 10'h155 : 10'($urandom_range(0, 1023));
            issue_cfg(MODE_SCROLL, 10'h201, n0);
            m = n0 + $urandom_range(9, 12);
            wait_until(m - 1);
            evt_pattern = ep;
            evt_req     = 1'b1;
            wait_until(m + $urandom_range(1, 8));
            evt_req     = 1'b0;
            evt_pattern = 10'($urandom_range(0, 1023));
            hi = m + 18;
            wait_until(hi);
            collect(n0, hi);
            exp_q.delete();
            nack = 0;
`ifdef CODECRACKER_LED_SEQ_EVENT_EN
            for (int k = 0; k < 3; k++) exp_q.push_back('{n0 + 1 + TD * k, exp_frame(3, 'h201, k)});
            exp_q.push_back('{m + 1, ep});
            for (int k = 2; k < 5; k++) exp_q.push_back('{m + 1 + HT * TD + TD * (k - 2), exp_frame(3, 'h201, k)});
            nack = 1;
`else
            for (int k = 0; n0 + 1 + TD * k <= hi; k++) exp_q.push_back('{n0 + 1 + TD * k, exp_frame(3, 'h201, k)});
`endif
            checks++;
            if (got.size() !== exp_q.size())
                $display("FAIL event_count: got %0d writes, expected %0d", got.size(), exp_q.size());
            else passes++;
            for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
                checks++;
                if (got[i].t !== exp_q[i].t || got[i].d !== exp_q[i].d)
                    $display("FAIL event_write%0d: got t=%0d d=0x%03h, expected t=%0d d=0x%03h",
                             i, got[i].t, got[i].d, exp_q[i].t, exp_q[i].d);
                else passes++;
            end
            checks++;
            if (ack_q.size() !== nack || (nack == 1 && ack_q[0] !== m + 1))
                $display("FAIL event_ack: got %0d acks (first t=%0d), expected %0d at t=%0d",
                         ack_q.size(), (ack_q.size() > 0) ? ack_q[0] : 0, nack, m + 1);
            else passes++;
        end
    endtask

    task automatic test_simultaneous;
        logic [9:0]  sp, ep;
        int unsigned mm, nack;
        for (int it = 0; it < 2; it++) begin
            ack_q.delete();
            sp = (it == 0) ? 10'h0F0 : 10'($urandom_range(0, 1023));
            ep = (it == 0) ? 10'h3C3 : 10'($urandom_range(0, 1023));
            mm = cyc + 1;
            cfg_mode    = MODE_STATIC;
            cfg_pattern = sp;
            cfg_valid   = 1'b1;
            evt_pattern = ep;
            evt_req     = 1'b1;
            @(posedge clk);
            #1;
            cfg_valid = 1'b0;
            evt_req   = 1'b0;
            wait_until(mm + 30);
            collect(mm, mm + 30);
            exp_q.delete();
`ifdef CODECRACKER_LED_SEQ_EVENT_EN
            exp_q.push_back('{mm + 1, ep});
            exp_q.push_back('{mm + 1 + HT * TD, sp});
            nack = 1;
`else
            exp_q.push_back('{mm + 1, sp});
            nack = 0;
`endif
            checks++;
            if (got.size() !== exp_q.size())
                $display("FAIL simul_count: got %0d writes, expected %0d", got.size(), exp_q.size());
            else passes++;
            for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
                checks++;
                if (got[i].t !== exp_q[i].t || got[i].d !== exp_q[i].d)
                    $display("FAIL simul_write%0d: got t=%0d d=0x%03h, expected t=%0d d=0x%03h",
                             i, got[i].t, got[i].d, exp_q[i].t, exp_q[i].d);
                else passes++;
            end
            checks++;
            if (ack_q.size() !== nack || (nack == 1 && ack_q[0] !== mm + 1))
                $display("FAIL simul_ack: got %0d acks, expected %0d at t=%0d", ack_q.size(), nack, mm + 1);
            else passes++;
            checks++;
            if (busy !== 1'b0) $display("FAIL simul_idle: got busy=%b, expected 0", busy);
            else passes++;
        end
    endtask

    task automatic test_event_idle;
        logic [1:0]  mode;
        logic [9:0]  sp, ep;
        int unsigned n, mm;
        for (int it = 0; it < 2; it++) begin
            mode = (it == 0) ? MODE_STATIC : MODE_OFF;
            sp   = 10'($urandom_range(0, 1023));
            ep   = 10'($urandom_range(0, 1023));
            issue_cfg(mode, sp, n);
            wait_until(n + 5);
            mm = cyc + 1;
            evt_pattern = ep;
            evt_req     = 1'b1;
            @(posedge clk);
            #1;
            evt_req = 1'b0;
            wait_until(mm + 30);
            collect(mm, mm + 30);
            exp_q.delete();
`ifdef CODECRACKER_LED_SEQ_EVENT_EN
            exp_q.push_back('{mm + 1, ep});
            exp_q.push_back('{mm + 1 + HT * TD, exp_frame(int'(mode), int'(sp), 0)});
`endif
            checks++;
            if (got.size() !== exp_q.size())
                $display("FAIL idle_evt_count: got %0d writes, expected %0d", got.size(), exp_q.size());
            else passes++;
            for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
                checks++;
                if (got[i].t !== exp_q[i].t || got[i].d !== exp_q[i].d)
                    $display("FAIL idle_evt_write%0d: got t=%0d d=0x%03h, expected t=%0d d=0x%03h",
                             i, got[i].t, got[i].d, exp_q[i].t, exp_q[i].d);
                else passes++;
            end
            checks++;
            if (busy !== 1'b0) $display("FAIL idle_evt_busy: got %b, expected 0", busy);
            else passes++;
        end
    endtask

    task automatic test_reset_abort;
        int unsigned n, c0;
        issue_cfg(MODE_BLINK, 10'($urandom_range(1, 1023)), n);
        checks++;
        if (avm_chipselect !== 1'b1) $display("FAIL abort_pre: got cs=%b, expected 1", avm_chipselect);
        else passes++;
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (avm_chipselect !== 1'b0 || avm_write_n !== 1'b1 || busy !== 1'b0 || avm_writedata !== 32'd0)
            $display("FAIL abort_now: got cs=%b wn=%b busy=%b data=0x%0h, expected 0 1 0 0x0",
                     avm_chipselect, avm_write_n, busy, avm_writedata);
        else passes++;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        c0 = cyc;
        wait_until(c0 + 30);
        collect(c0, c0 + 30);
        checks++;
        if (got.size() !== 0) $display("FAIL abort_nowrite: got %0d writes, expected 0", got.size());
        else passes++;
    endtask

    initial begin
        test_reset();
        test_static();
        test_animate(MODE_BLINK, 10'h3FF, 5);
        test_animate(MODE_SCROLL, 10'h201, 6);
        test_cfg_override();
        test_event();
        test_simultaneous();
        test_event_idle();
        test_reset_abort();
        checks++;
        if (proto_err !== 0) $display("FAIL bus_protocol: got %0d bad cycles, expected 0", proto_err);
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
